// File: rtl/video_timing_detect.sv
// ---------------------------------------------------------------------------
// video_timing_detect
//
// Receive-side timing analyser for a raw hsync/vsync/de pixel stream. It
// measures line and frame geometry, recovers active-area pixel coordinates
// and raises `locked` once consecutive frames measure identically.
//
// Optional build macro:
//   AUTO_POL_EN - sync polarity is learned from the stream (syncs are
//                 inactive while de is high). Without it the H_POL/V_POL
//                 parameters select normalization.
//
// Ports:
//   clk_pix   pixel clock
//   rst       asynchronous, active-high reset
//   hsync     raw horizontal sync (clk_pix domain)
//   vsync     raw vertical sync (clk_pix domain)
//   de        raw data enable
//   de_out    de delayed by 2 clocks, aligned with sx/sy
//   sx, sy    recovered active column / row (hold while de_out=0)
//   frame     one-cycle pulse per normalized vsync rising edge
//   locked    timing stable
//   h_total   clocks per line         h_active  de clocks per line
//   v_total   lines per frame         v_active  lines with de per frame
//   h_pol     hsync polarity in use   v_pol     vsync polarity in use
// ---------------------------------------------------------------------------
module video_timing_detect #(
    parameter int CNTW        = 12,
    parameter bit H_POL       = 1'b1,
    parameter bit V_POL       = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk_pix,
    input  logic            rst,
    input  logic            hsync,
    input  logic            vsync,
    input  logic            de,
    output logic            de_out,
    output logic [CNTW-1:0] sx,
    output logic [CNTW-1:0] sy,
    output logic            frame,
    output logic            locked,
    output logic [CNTW-1:0] h_total,
    output logic [CNTW-1:0] h_active,
    output logic [CNTW-1:0] v_total,
    output logic [CNTW-1:0] v_active,
    output logic            h_pol,
    output logic            v_pol
);

    localparam logic [CNTW-1:0] CNT_ZERO   = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_ONE    = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};
    localparam logic [3:0]      MATCH_LOCK = 4'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Input pipeline
    logic hsync_q_r, vsync_q_r, de_q_r;
    logic hsync_q2_r, vsync_q2_r;
    logic h_pol_r, v_pol_r;
    logic h_pol_nx_s, v_pol_nx_s, pol_change_s;

    // Normalized sync edges
    logic hs_s, hs_d_s, hs_rise_s;
    logic vs_s, vs_d_s, vs_rise_s;

    // Line / frame measurement
    logic [CNTW-1:0] hcnt_r, decnt_r, line_len_r, line_act_r;
    logic [CNTW-1:0] vcnt_r, vacnt_r;
    logic            line_de_seen_r, frame_de_seen_r;
    logic [CNTW-1:0] line_len_nx_s, line_act_nx_s, vcnt_nx_s, vacnt_nx_s;
    logic            line_has_de_s, timeout_s, snap_diff_s, len_err_s;

    // Outputs
    logic [CNTW-1:0] h_total_r, h_active_r, v_total_r, v_active_r;
    logic [CNTW-1:0] sx_r, sy_r, sx_nx_s, sy_nx_s;
    logic            de_out_r, frame_r, locked_r;

    // FSM
    state_t     state_r, state_nx_s;
    logic [3:0] match_r, match_nx_s, match_inc_s;

    // Both sync taps are normalized with the current polarity so that a
    // polarity update never fabricates an edge.
    assign hs_s      = hsync_q_r ~^ h_pol_r;
    assign hs_d_s    = hsync_q2_r ~^ h_pol_r;
    assign hs_rise_s = hs_s & ~hs_d_s;
    assign vs_s      = vsync_q_r ~^ v_pol_r;
    assign vs_d_s    = vsync_q2_r ~^ v_pol_r;
    assign vs_rise_s = vs_s & ~vs_d_s;

    assign timeout_s     = (hcnt_r == CNT_MAX);
    assign line_has_de_s = line_de_seen_r | de_q_r;
    assign match_inc_s   = match_r + 4'd1;

    // Input stage registers and sync polarity tracking
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            hsync_q_r  <= 1'b0;
            vsync_q_r  <= 1'b0;
            de_q_r     <= 1'b0;
            hsync_q2_r <= 1'b0;
            vsync_q2_r <= 1'b0;
            h_pol_r    <= H_POL;
            v_pol_r    <= V_POL;
        end else begin
            hsync_q_r  <= hsync;
            vsync_q_r  <= vsync;
            de_q_r     <= de;
            hsync_q2_r <= hsync_q_r;
            vsync_q2_r <= vsync_q_r;
            h_pol_r    <= h_pol_nx_s;
            v_pol_r    <= v_pol_nx_s;
        end
    end

    // Polarity selection: learned from idle sync level during active video, or fixed
    always_comb begin
        h_pol_nx_s   = h_pol_r;
        v_pol_nx_s   = v_pol_r;
        pol_change_s = 1'b0;
`ifdef AUTO_POL_EN
        if (de_q_r) begin
            h_pol_nx_s   = ~hsync_q_r;
            v_pol_nx_s   = ~vsync_q_r;
            pol_change_s = (hsync_q_r == h_pol_r) | (vsync_q_r == v_pol_r);
        end else begin
            h_pol_nx_s   = h_pol_r;
            v_pol_nx_s   = v_pol_r;
            pol_change_s = 1'b0;
        end
`else
        h_pol_nx_s   = H_POL;
        v_pol_nx_s   = V_POL;
        pol_change_s = 1'b0;
`endif
    end

    // Next line/frame statistics; a simultaneous hs_rise is folded into a vs_rise snapshot
    always_comb begin
        line_len_nx_s = line_len_r;
        line_act_nx_s = line_act_r;
        vcnt_nx_s     = vcnt_r;
        vacnt_nx_s    = vacnt_r;
        if (hs_rise_s) begin
            line_len_nx_s = hcnt_r + CNT_ONE;
            vcnt_nx_s     = vcnt_r + CNT_ONE;
            // Blank lines keep the last active width so the snapshot taken in
            // vertical blanking still reports the active line width.
            if (line_has_de_s) begin
                line_act_nx_s = decnt_r;
                vacnt_nx_s    = vacnt_r + CNT_ONE;
            end else begin
                line_act_nx_s = line_act_r;
                vacnt_nx_s    = vacnt_r;
            end
        end else begin
            line_len_nx_s = line_len_r;
            line_act_nx_s = line_act_r;
            vcnt_nx_s     = vcnt_r;
            vacnt_nx_s    = vacnt_r;
        end
    end

    assign snap_diff_s = (line_len_nx_s != h_total_r)  | (line_act_nx_s != h_active_r) |
                         (vcnt_nx_s     != v_total_r)  | (vacnt_nx_s    != v_active_r);
    assign len_err_s   = hs_rise_s & (line_len_nx_s != h_total_r);

    // Line and frame counters plus measurement snapshot
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            hcnt_r          <= CNT_ZERO;
            decnt_r         <= CNT_ZERO;
            line_len_r      <= CNT_ZERO;
            line_act_r      <= CNT_ZERO;
            line_de_seen_r  <= 1'b0;
            vcnt_r          <= CNT_ZERO;
            vacnt_r         <= CNT_ZERO;
            frame_de_seen_r <= 1'b0;
            h_total_r       <= CNT_ZERO;
            h_active_r      <= CNT_ZERO;
            v_total_r       <= CNT_ZERO;
            v_active_r      <= CNT_ZERO;
        end else begin
            if (hs_rise_s) begin
                hcnt_r  <= CNT_ZERO;
                decnt_r <= CNT_ZERO;
            end else begin
                hcnt_r  <= timeout_s ? hcnt_r : hcnt_r + CNT_ONE;
                decnt_r <= (de_q_r && decnt_r != CNT_MAX) ? decnt_r + CNT_ONE : decnt_r;
            end
            line_len_r     <= line_len_nx_s;
            line_act_r     <= line_act_nx_s;
            line_de_seen_r <= hs_rise_s ? 1'b0 : line_has_de_s;
            if (vs_rise_s) begin
                vcnt_r          <= CNT_ZERO;
                vacnt_r         <= CNT_ZERO;
                frame_de_seen_r <= 1'b0;
                h_total_r       <= line_len_nx_s;
                h_active_r      <= line_act_nx_s;
                v_total_r       <= vcnt_nx_s;
                v_active_r      <= vacnt_nx_s;
            end else begin
                vcnt_r          <= vcnt_nx_s;
                vacnt_r         <= vacnt_nx_s;
                frame_de_seen_r <= frame_de_seen_r | de_q_r;
            end
        end
    end

    // Coordinate recovery: sx restarts on the first de of a line, sy on the first active line of a frame
    always_comb begin
        sx_nx_s = sx_r;
        sy_nx_s = sy_r;
        if (de_q_r) begin
            if (line_de_seen_r) begin
                sx_nx_s = sx_r + CNT_ONE;
                sy_nx_s = sy_r;
            end else begin
                sx_nx_s = CNT_ZERO;
                sy_nx_s = (frame_de_seen_r & ~vs_rise_s) ? sy_r + CNT_ONE : CNT_ZERO;
            end
        end else begin
            sx_nx_s = sx_r;
            sy_nx_s = sy_r;
        end
    end

    // Lock FSM next state
    always_comb begin
        state_nx_s = state_r;
        match_nx_s = match_r;
        case (state_r)
            ST_SEARCH: begin
                if (vs_rise_s) begin
                    state_nx_s = ST_MEASURE;
                    match_nx_s = 4'd0;
                end else begin
                    state_nx_s = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (timeout_s) begin
                    state_nx_s = ST_SEARCH;
                    match_nx_s = 4'd0;
                end else if (vs_rise_s) begin
                    if (snap_diff_s) begin
                        match_nx_s = 4'd0;
                    end else if (match_inc_s >= MATCH_LOCK) begin
                        match_nx_s = match_inc_s;
                        state_nx_s = ST_LOCKED;
                    end else begin
                        match_nx_s = match_inc_s;
                    end
                end else begin
                    state_nx_s = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (timeout_s || pol_change_s || len_err_s || (vs_rise_s && snap_diff_s)) begin
                    state_nx_s = ST_SEARCH;
                    match_nx_s = 4'd0;
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                state_nx_s = ST_SEARCH;
                match_nx_s = 4'd0;
            end
        endcase
    end

    // FSM state and registered status/coordinate outputs
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_r  <= ST_SEARCH;
            match_r  <= 4'd0;
            locked_r <= 1'b0;
            frame_r  <= 1'b0;
            de_out_r <= 1'b0;
            sx_r     <= CNT_ZERO;
            sy_r     <= CNT_ZERO;
        end else begin
            state_r  <= state_nx_s;
            match_r  <= match_nx_s;
            locked_r <= (state_nx_s == ST_LOCKED);
            frame_r  <= vs_rise_s;
            de_out_r <= de_q_r;
            sx_r     <= sx_nx_s;
            sy_r     <= sy_nx_s;
        end
    end

    assign de_out   = de_out_r;
    assign sx       = sx_r;
    assign sy       = sy_r;
    assign frame    = frame_r;
    assign locked   = locked_r;
    assign h_total  = h_total_r;
    assign h_active = h_active_r;
    assign v_total  = v_total_r;
    assign v_active = v_active_r;
    assign h_pol    = h_pol_r;
    assign v_pol    = v_pol_r;

endmodule
